// File: rtl/digit_entry_ctrl.sv
// digit_entry_ctrl: operator-input front end for the 8-digit display.
// It synchronises the raw switches and buttons and debounces both buttons.
// It then turns each accepted press into num/sel/wr write traffic:
//   - a write press stores one digit at an auto-advancing cursor;
//   - a clear press sweeps zeros into all eight digits.
// Every output is taken directly from a register.

module digit_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [3:0] sw_num,
  input  logic       btn_wr,
  input  logic       btn_clr,
  output logic [3:0] num,
  output logic [2:0] sel,
  output logic       wr,
  output logic       busy
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1 before the level toggles.
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Button vectors: bit 0 = write button, bit 1 = clear button.
  localparam int B_WR  = 0;
  localparam int B_CLR = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  logic [1:0]    r_btn_meta;
  logic [1:0]    r_btn_s;
  logic [3:0]    r_sw_meta;
  logic [3:0]    r_sw_s;
  logic [1:0]    r_stable;
  logic [1:0]    r_stable_d;
  logic [CW-1:0] r_cnt [2];

  state_t        r_state;
  logic [2:0]    r_cursor;
  logic [2:0]    r_idx;
  logic [3:0]    r_num;
  logic [2:0]    r_sel;
  logic          r_wr;
  logic          r_busy;

  logic          w_wr_press;
  logic          w_clr_press;

  // Two-flop synchronisers for the raw buttons and data switches.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_btn_meta <= 2'b00;
      r_btn_s    <= 2'b00;
      r_sw_meta  <= 4'd0;
      r_sw_s     <= 4'd0;
    end else begin
      r_btn_meta <= {btn_clr, btn_wr};
      r_btn_s    <= r_btn_meta;
      r_sw_meta  <= sw_num;
      r_sw_s     <= r_sw_meta;
    end
  end

  // Debounce: the stable level follows the synchronised button only after
  // DEBOUNCE_CYCLES consecutive disagreeing samples; any agreement restarts.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_stable   <= 2'b00;
      r_stable_d <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_stable_d <= r_stable;
      for (int i = 0; i < 2; i++) begin
        if (r_btn_s[i] != r_stable[i]) begin
          if (r_cnt[i] == CNT_MAX) begin
            r_stable[i] <= ~r_stable[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i]    <= r_cnt[i] + {{(CW-1){1'b0}}, 1'b1};
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // A press is the rising edge of the debounced level; holding never repeats.
  assign w_wr_press  = r_stable[B_WR]  & ~r_stable_d[B_WR];
  assign w_clr_press = r_stable[B_CLR] & ~r_stable_d[B_CLR];

  // Control FSM with registered outputs. Clear beats write in the same cycle.
  // Presses arriving outside IDLE are simply dropped.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cursor <= 3'd0;
      r_idx    <= 3'd0;
      r_num    <= 4'd0;
      r_sel    <= 3'd0;
      r_wr     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_clr_press) begin
            r_state <= S_CLEAR;
            r_idx   <= 3'd0;
            r_sel   <= 3'd0;
            r_num   <= 4'd0;
            r_wr    <= 1'b1;
            r_busy  <= 1'b1;
          end else if (w_wr_press) begin
            r_state <= S_WRITE;
            r_num   <= r_sw_s;
            r_sel   <= r_cursor;
            r_wr    <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_sel   <= r_cursor;
            r_wr    <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        S_WRITE: begin
          // One-cycle write, then advance the cursor (wraps 7 -> 0).
          r_state  <= S_IDLE;
          r_cursor <= r_cursor + 3'd1;
          r_sel    <= r_cursor + 3'd1;
          r_wr     <= 1'b0;
          r_busy   <= 1'b0;
        end
        S_CLEAR: begin
          if (r_idx == 3'd7) begin
            r_state  <= S_IDLE;
            r_idx    <= 3'd0;
            r_cursor <= 3'd0;
            r_sel    <= 3'd0;
            r_num    <= 4'd0;
            r_wr     <= 1'b0;
            r_busy   <= 1'b0;
          end else begin
            r_idx    <= r_idx + 3'd1;
            r_sel    <= r_idx + 3'd1;
            r_num    <= 4'd0;
            r_wr     <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_wr    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign num  = r_num;
  assign sel  = r_sel;
  assign wr   = r_wr;
  assign busy = r_busy;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Directed, table-driven bench for digit_entry_ctrl with DEBOUNCE_CYCLES=4.
module tb_digit_entry_ctrl;

  logic       CLK = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sw_num = 4'd0;
  logic       btn_wr = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] num;
  logic [2:0] sel;
  logic       wr;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int busy_cnt = 0;

  typedef struct {
    int cyc;
    int sel;
    int num;
    int busy;
  } wrrec_t;
  wrrec_t log_q[$];

  typedef struct {
    logic [3:0] sw;
    logic [2:0] exp_sel;
    logic [3:0] exp_num;
  } vec_t;
  vec_t vecs[8];

  digit_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK(CLK), .rst(rst), .sw_num(sw_num), .btn_wr(btn_wr), .btn_clr(btn_clr),
    .num(num), .sel(sel), .wr(wr), .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: record every write cycle and every busy cycle, mid-cycle.
  always @(negedge CLK) begin
    if (rst && wr) log_q.push_back('{cyc, int'(sel), int'(num), int'(busy)});
    if (rst && busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic press_wr(input logic [3:0] v);
    @(negedge CLK);
    sw_num = v;
    btn_wr = 1'b1;
    repeat (8) @(negedge CLK);
    btn_wr = 1'b0;
    repeat (8) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    rst = 1'b0;
    repeat (3) @(negedge CLK);
    rst = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int t0;
    int sel_before;
    int n;

    vecs[0] = '{4'd2,  3'd0, 4'd2};
    vecs[1] = '{4'd5,  3'd1, 4'd5};
    vecs[2] = '{4'd14, 3'd2, 4'd14};
    vecs[3] = '{4'd14, 3'd3, 4'd14};
    vecs[4] = '{4'd1,  3'd4, 4'd1};
    vecs[5] = '{4'd2,  3'd5, 4'd2};
    vecs[6] = '{4'd0,  3'd6, 4'd0};
    vecs[7] = '{4'd2,  3'd7, 4'd2};

    // 1. Reset values
    rst = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_num", num, 0);
    chk("reset_sel", sel, 0);
    chk("reset_wr", wr, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b1;
    repeat (50) @(negedge CLK);
    chk("reset_no_wr", log_q.size(), 0);

    // 2. Single write: wr at edge 7 after the first edge sampling the press
    log_q.delete();
    @(negedge CLK);
    sw_num = 4'd2;
    btn_wr = 1'b1;
    t0 = cyc;
    repeat (20) @(negedge CLK);
    btn_wr = 1'b0;
    repeat (10) @(negedge CLK);
    chk("single_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("single_edge", log_q[0].cyc - t0, 7);
      chk("single_sel", log_q[0].sel, 0);
      chk("single_num", log_q[0].num, 2);
    end
    chk("single_after_sel", sel, 1);
    chk("single_after_num", num, 2);

    // 3. Cursor wrap, table-driven
    do_reset();
    log_q.delete();
    for (int i = 0; i < 8; i++) begin
      press_wr(vecs[i].sw);
      chk("wrap_count", log_q.size(), i + 1);
      if (log_q.size() == i + 1) begin
        chk("wrap_sel", log_q[i].sel, vecs[i].exp_sel);
        chk("wrap_num", log_q[i].num, vecs[i].exp_num);
      end
    end
    chk("wrap_final_sel", sel, 0);

    // 4. Glitch rejection
    log_q.delete();
    sel_before = sel;
    @(negedge CLK);
    btn_wr = 1'b1;
    repeat (3) @(negedge CLK);
    btn_wr = 1'b0;
    repeat (20) @(negedge CLK);
    chk("glitch_no_wr", log_q.size(), 0);
    chk("glitch_sel", sel, sel_before);

    // 5. Clear colliding with write
    press_wr(4'd3);
    press_wr(4'd4);
    press_wr(4'd5);
    chk("pre_clear_sel", sel, 3);
    log_q.delete();
    busy_cnt = 0;
    @(negedge CLK);
    btn_clr = 1'b1;
    btn_wr  = 1'b1;
    repeat (20) @(negedge CLK);
    btn_clr = 1'b0;
    btn_wr  = 1'b0;
    repeat (20) @(negedge CLK);
    chk("clear_count", log_q.size(), 8);
    chk("clear_busy_cycles", busy_cnt, 8);
    if (log_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("clear_sel", log_q[i].sel, i);
        chk("clear_num", log_q[i].num, 0);
        chk("clear_busy", log_q[i].busy, 1);
        chk("clear_consec", log_q[i].cyc - log_q[0].cyc, i);
      end
    end
    chk("clear_idle_sel", sel, 0);
    chk("clear_idle_num", num, 0);

    // 6. Reset in the middle of a sweep
    log_q.delete();
    @(negedge CLK);
    btn_clr = 1'b1;
    n = 0;
    while (log_q.size() < 4 && n < 60) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("sweep_reached_4", (log_q.size() >= 4) ? 1 : 0, 1);
    #2;
    rst = 1'b0;
    btn_clr = 1'b0;
    #1;
    chk("midreset_wr", wr, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_sel", sel, 0);
    chk("midreset_num", num, 0);
    repeat (2) @(negedge CLK);
    rst = 1'b1;
    log_q.delete();
    repeat (50) @(negedge CLK);
    chk("midreset_no_wr", log_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/digit_entry_ctrl.md
# digit_entry_ctrl

Operator-input front end for the 8-digit seven-segment display controller. It conditions the raw data switches and two push-buttons, then turns each press into the `num`/`sel`/`wr` write traffic the display stage consumes. A write press stores one digit at an auto-advancing cursor. A clear press sweeps zeros into all eight digits. Outputs connect directly to the display controller's `num`, `sel` and `wr` inputs.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable samples needed to accept a button level change (10 ms at 100 MHz). Legal range ≥ 2.

Ports:
- `CLK` — in, 1 — system clock; all state is on its rising edge.
- `rst` — in, 1 — asynchronous, active-low reset.
- `sw_num` — in, 4 — raw, asynchronous data switches.
- `btn_wr` — in, 1 — raw push-button: write the digit at the cursor, then advance the cursor.
- `btn_clr` — in, 1 — raw push-button: clear all eight digits.
- `num` — out, 4 — digit value presented to the display controller.
- `sel` — out, 3 — digit index. Equals the cursor when idle and the target digit during a write.
- `wr` — out, 1 — write strobe, high for exactly one cycle per digit written.
- `busy` — out, 1 — high while a clear sweep is running.

## Operation

**Input synchronisation**
- `btn_wr`, `btn_clr` and `sw_num` each pass through a 2-flop synchroniser. The second stage is called `*_s`.

**Debounce (one instance per button)**
- Each button has a counter and a stable level.
- When `*_s` differs from the stable level, the counter increments.
- When `*_s` equals the stable level, the counter is cleared.
- On the DEBOUNCE_CYCLES-th consecutive differing sample, the stable level toggles and the counter clears.
- A press event is the stable level being 1 while its 1-cycle delayed copy is 0.
- Holding a button never repeats. Release is debounced the same way.

**FSM states: IDLE, WRITE, CLEAR**
- **IDLE:** `wr=0`, `busy=0`, `sel=cursor`, `num` holds its last value.
  - On a clear press: go to CLEAR with `idx=0`.
  - Otherwise, on a write press: go to WRITE and latch `num <= sw_num_s`.
- **WRITE:** lasts one cycle.
  - `wr=1`, `sel=cursor`.
  - On exit, `cursor <= cursor+1`, modulo 8 (7 wraps to 0). Return to IDLE.
- **CLEAR:** lasts 8 cycles.
  - `wr=1`, `busy=1`, `num=0`, `sel=idx`, with `idx` running 0..7.
  - After `idx=7`: go to IDLE with `cursor <= 0` and `num` left at 0.

**Simultaneous events and ignored presses**
- If clear and write presses occur in the same cycle, clear wins and the write press is discarded.
- Presses arriving during WRITE or CLEAR are discarded, not queued.

**Output registers**
- All outputs come straight from registers; there is no combinational path from inputs to outputs.

**Reset**
- `rst=0` forces the following immediately, regardless of `CLK`:
  - `num=0`, `sel=0`, `wr=0`, `busy=0`
  - `cursor=0`, `idx=0`, state IDLE
  - synchronisers, stable levels and counters all at 0
- A sweep interrupted by reset is abandoned. No further `wr` pulses appear after reset is released.

## Timing

- Press latency is measured from edge 1, the first rising edge that samples the raw button high. The button must be held.
  - Stable level toggles at edge D+2, where D = DEBOUNCE_CYCLES.
  - FSM acts at edge D+3.
  - `wr` is high from edge D+3 to edge D+4.
- `num` during WRITE equals `sw_num_s` as sampled at edge D+3.
- Clear sweep: `wr` is high for 8 consecutive cycles starting at edge D+3. `busy` has identical timing.
- Minimum gap between two accepted writes on the same button: D cycles of debounced release plus D cycles of debounced press.
- Glitch rejection: a raw pulse lasting ≤ D−1 sampled cycles produces no event.

## Test plan

Run with DEBOUNCE_CYCLES=4 and a 10 ns clock.

1. **Reset values.** Hold `rst=0` for 3 cycles with buttons idle → `num=0`, `sel=0`, `wr=0`, `busy=0`. After release, no `wr` over 50 cycles.
2. **Single write.** `sw_num=2`, hold `btn_wr` for 20 cycles → exactly one `wr` pulse, at edge 7, with `sel=0`, `num=2`. Afterwards `sel=1` and `num` stays 2.
3. **Cursor wrap.** Eight press/release cycles with `sw_num` = 2, 5, 14, 14, 1, 2, 0, 2 → `wr` pulses on `sel` = 0..7 with matching `num`. Final idle `sel=0`.
4. **Glitch rejection.** `btn_wr` high for 3 cycles, then low → no `wr`, `sel` unchanged.
5. **Clear with collision.** After 3 writes, press `btn_clr` and `btn_wr` together → 8 consecutive `wr` cycles with `sel` 0..7 and `num=0`, `busy` high for those 8 cycles. No extra write pulse. Idle `sel=0`.
6. **Reset mid-sweep.** Assert `rst=0` during the 4th clear cycle, between clock edges → `wr`, `busy`, `sel` and `num` drop to 0 immediately. After release, no `wr` within 50 cycles.
